// File: rtl/fpu_issue_ctrl.sv
// Single-issue dispatch controller for the FP cluster: register scoreboard,
// routing to pipe / div-sqrt / load-store, and the shared writeback arbiter.
module fpu_issue_ctrl #(
    parameter int VIR_REG_ADDR = 6,
    parameter int PIPE_LAT     = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    issue_valid_i,
    output logic                    issue_ready_o,
    input  logic                    uses_rs1_i,
    input  logic                    uses_rs2_i,
    input  logic                    uses_rs3_i,
    input  logic                    uses_rd_i,
    input  logic [VIR_REG_ADDR-1:0] rs1_addr_i,
    input  logic [VIR_REG_ADDR-1:0] rs2_addr_i,
    input  logic [VIR_REG_ADDR-1:0] rs3_addr_i,
    input  logic [VIR_REG_ADDR-1:0] rd_addr_i,
    input  logic [4:0]              fu_function_i,
    output logic                    pipe_start_o,
    output logic                    div_start_o,
    input  logic                    div_done_i,
    output logic                    div_wb_o,
    output logic                    lsu_req_o,
    input  logic                    lsu_resp_valid_i,
    output logic                    lsu_wb_o,
    output logic [4:0]              func_o,
    output logic                    wb_valid_o,
    output logic [VIR_REG_ADDR-1:0] wb_rd_o,
    output logic [1:0]              wb_sel_o,
    output logic                    idle_o
);

    localparam int NUM_REGS = 1 << VIR_REG_ADDR;

    typedef enum logic [2:0] {
        CLS_PIPE  = 3'd0,
        CLS_DIV   = 3'd1,
        CLS_LOAD  = 3'd2,
        CLS_STORE = 3'd3,
        CLS_RSVD  = 3'd4
    } fu_class_e;

    localparam logic [1:0] SEL_PIPE = 2'd0;
    localparam logic [1:0] SEL_DIV  = 2'd1;
    localparam logic [1:0] SEL_LSU  = 2'd2;

    // Handshakes: an instruction transfers when issue_valid_i & issue_ready_o
    // are both high in a cycle; div_done_i / lsu_resp_valid_i are held by the
    // unit until the matching div_wb_o / lsu_wb_o pulse consumes them.

    logic [NUM_REGS-1:0]     pending_q, pending_next;
    logic [PIPE_LAT-1:0]     pipe_v_q, pipe_h_q;
    logic [VIR_REG_ADDR-1:0] pipe_rd_q [PIPE_LAT];
    logic                    div_busy_q, div_has_rd_q;
    logic [VIR_REG_ADDR-1:0] div_rd_q;
    logic                    lsu_busy_q, lsu_write_q;
    logic [VIR_REG_ADDR-1:0] lsu_rd_q;

    fu_class_e fu_class;
    logic      src_hazard, dst_hazard, unit_hazard;
    logic      fire, dest_has_rd, set_pending;
    logic      pipe_exit_wr, div_wr, lsu_wr;

    always_comb begin
        fu_class = CLS_RSVD;
        if (fu_function_i <= 5'd25)      fu_class = CLS_PIPE;
        else if (fu_function_i <= 5'd27) fu_class = CLS_DIV;
        else if (fu_function_i == 5'd28) fu_class = CLS_LOAD;
        else if (fu_function_i == 5'd29) fu_class = CLS_STORE;
    end

    // Readiness only looks at registered state: no bypass from this cycle's writeback.
    always_comb begin
        src_hazard  = (uses_rs1_i && pending_q[rs1_addr_i]) ||
                      (uses_rs2_i && pending_q[rs2_addr_i]) ||
                      (uses_rs3_i && pending_q[rs3_addr_i]);
        dst_hazard  = uses_rd_i && pending_q[rd_addr_i];
        unit_hazard = ((fu_class == CLS_DIV) && div_busy_q) ||
                      (((fu_class == CLS_LOAD) || (fu_class == CLS_STORE)) && lsu_busy_q);
        issue_ready_o = !(src_hazard || dst_hazard || unit_hazard);
    end

    assign fire        = issue_valid_i && issue_ready_o;
    assign dest_has_rd = uses_rd_i && (fu_class != CLS_STORE) && (fu_class != CLS_RSVD);
    assign set_pending = fire && dest_has_rd && (rd_addr_i != '0);

    always_comb begin
        pipe_start_o = fire && (fu_class == CLS_PIPE);
        div_start_o  = fire && (fu_class == CLS_DIV);
        lsu_req_o    = fire && ((fu_class == CLS_LOAD) || (fu_class == CLS_STORE));
        func_o       = '0;
        if (pipe_start_o || div_start_o || lsu_req_o)
            func_o = fu_function_i;
    end

    // Fixed priority pipe > div > LSU; only results that write need the port.
    always_comb begin
        pipe_exit_wr = pipe_v_q[PIPE_LAT-1] && pipe_h_q[PIPE_LAT-1];
        div_wb_o     = div_busy_q && div_done_i && !(div_has_rd_q && pipe_exit_wr);
        div_wr       = div_wb_o && div_has_rd_q;
        lsu_wb_o     = lsu_busy_q && lsu_resp_valid_i &&
                       (!lsu_write_q || (!pipe_exit_wr && !div_wr));
        lsu_wr       = lsu_wb_o && lsu_write_q;

        wb_valid_o = 1'b0;
        wb_rd_o    = '0;
        wb_sel_o   = SEL_PIPE;
        if (pipe_exit_wr) begin
            wb_valid_o = 1'b1;
            wb_rd_o    = pipe_rd_q[PIPE_LAT-1];
            wb_sel_o   = SEL_PIPE;
        end else if (div_wr) begin
            wb_valid_o = 1'b1;
            wb_rd_o    = div_rd_q;
            wb_sel_o   = SEL_DIV;
        end else if (lsu_wr) begin
            wb_valid_o = 1'b1;
            wb_rd_o    = lsu_rd_q;
            wb_sel_o   = SEL_LSU;
        end
    end

    // Writeback and issue never touch the same register in one cycle (WAW stall).
    always_comb begin
        pending_next = pending_q;
        if (wb_valid_o)
            pending_next[wb_rd_o] = 1'b0;
        if (set_pending)
            pending_next[rd_addr_i] = 1'b1;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q    <= '0;
            pipe_v_q     <= '0;
            pipe_h_q     <= '0;
            for (int i = 0; i < PIPE_LAT; i++)
                pipe_rd_q[i] <= '0;
            div_busy_q   <= 1'b0;
            div_has_rd_q <= 1'b0;
            div_rd_q     <= '0;
            lsu_busy_q   <= 1'b0;
            lsu_write_q  <= 1'b0;
            lsu_rd_q     <= '0;
        end else begin
            pending_q <= pending_next;

            pipe_v_q[0]  <= pipe_start_o;
            pipe_h_q[0]  <= pipe_start_o && dest_has_rd;
            pipe_rd_q[0] <= rd_addr_i;
            for (int i = 1; i < PIPE_LAT; i++) begin
                pipe_v_q[i]  <= pipe_v_q[i-1];
                pipe_h_q[i]  <= pipe_h_q[i-1];
                pipe_rd_q[i] <= pipe_rd_q[i-1];
            end

            if (div_start_o) begin
                div_busy_q   <= 1'b1;
                div_has_rd_q <= dest_has_rd;
                div_rd_q     <= rd_addr_i;
            end else if (div_wb_o) begin
                div_busy_q   <= 1'b0;
            end

            if (lsu_req_o) begin
                lsu_busy_q  <= 1'b1;
                lsu_write_q <= dest_has_rd;
                lsu_rd_q    <= rd_addr_i;
            end else if (lsu_wb_o) begin
                lsu_busy_q  <= 1'b0;
            end
        end
    end

    assign idle_o = (pending_q == '0) && (pipe_v_q == '0) && !div_busy_q && !lsu_busy_q;

endmodule
